// File: rtl/memory_flash_burst_reader.sv
// Serves word-read requests from a burst-capable flash port. Words past FLASH_END
// are not read from flash and are returned as zero, so every request gets exactly L acks.
module memory_flash_burst_reader #(
    parameter int                ADDR_W    = 19,
    parameter logic [ADDR_W-1:0] FLASH_END = 19'h059FF,
    parameter int                MAX_BURST = 4,
    parameter bit                SWAP      = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_request,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [3:0]        i_length,
    output logic              o_busy,
    output logic              o_ack,
    output logic [31:0]       o_data,
    output logic              o_flash_read,
    output logic [ADDR_W-1:0] o_flash_address,
    output logic [3:0]        o_flash_burstcount,
    input  logic              i_flash_waitrequest,
    input  logic              i_flash_readdatavalid,
    input  logic [31:0]       i_flash_readdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] COLLECT = 2'd2;
    localparam logic [1:0] DUMMY   = 2'd3;

    localparam logic [3:0]      MAX_LEN = 4'(MAX_BURST);
    localparam logic [ADDR_W:0] END_EXT = {1'b0, FLASH_END};
    localparam logic [ADDR_W:0] ONE_EXT = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        n_q, n_d;
    logic [3:0]        beat_q, beat_d;
    logic [3:0]        dummy_q, dummy_d;
    logic              ack_q, ack_d;
    logic [31:0]       data_q, data_d;

    logic [3:0]        len_clamp;
    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W:0]   avail;
    logic [ADDR_W:0]   len_ext;
    logic [3:0]        n_calc;
    logic [31:0]       beat_data;

    // In-range word count, computed one bit wider than the address so that
    // FLASH_END - A + 1 cannot wrap.
    always_comb begin
        if (i_length == 4'd0) begin
            len_clamp = 4'd1;
        end else if (i_length > MAX_LEN) begin
            len_clamp = MAX_LEN;
        end else begin
            len_clamp = i_length;
        end
        addr_ext = {1'b0, i_address};
        avail    = END_EXT - addr_ext + ONE_EXT;
        len_ext  = {{(ADDR_W-3){1'b0}}, len_clamp};
        if (addr_ext > END_EXT) begin
            n_calc = 4'd0;
        end else if (len_ext <= avail) begin
            n_calc = len_clamp;
        end else begin
            n_calc = avail[3:0];
        end
    end

    generate
        if (SWAP) begin : g_swap
            assign beat_data = {i_flash_readdata[7:0], i_flash_readdata[15:8],
                                i_flash_readdata[23:16], i_flash_readdata[31:24]};
        end else begin : g_raw
            assign beat_data = i_flash_readdata;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        n_d     = n_q;
        beat_d  = beat_q;
        dummy_d = dummy_q;
        ack_d   = 1'b0;
        data_d  = 32'd0;
        case (state_q)
            IDLE: begin
                if (i_request) begin
                    addr_d = i_address;
                    len_d  = len_clamp;
                    n_d    = n_calc;
                    beat_d = 4'd0;
                    if (n_calc != 4'd0) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = DUMMY;
                        dummy_d = len_clamp;
                    end
                end
            end
            ISSUE: begin
                if (!i_flash_waitrequest) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (i_flash_readdatavalid) begin
                    ack_d  = 1'b1;
                    data_d = beat_data;
                    beat_d = beat_q + 4'd1;
                    if (beat_q + 4'd1 == n_q) begin
                        if (len_q > n_q) begin
                            state_d = DUMMY;
                            dummy_d = len_q - n_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            DUMMY: begin
                ack_d   = 1'b1;
                dummy_d = dummy_q - 4'd1;
                if (dummy_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= 4'd0;
            n_q     <= 4'd0;
            beat_q  <= 4'd0;
            dummy_q <= 4'd0;
            ack_q   <= 1'b0;
            data_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            n_q     <= n_d;
            beat_q  <= beat_d;
            dummy_q <= dummy_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
        end
    end

    assign o_busy             = (state_q != IDLE);
    assign o_flash_read       = (state_q == ISSUE);
    assign o_flash_address    = o_flash_read ? addr_q : '0;
    assign o_flash_burstcount = o_flash_read ? n_q : 4'd0;
    assign o_ack              = ack_q;
    assign o_data             = data_q;

endmodule

// File: tb/tb_memory_flash_burst_reader.sv
// Directed bench for memory_flash_burst_reader: a small flash responder drives beats
// while a per-request loop records acks; results are compared with hand-computed values.
module tb_memory_flash_burst_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req, busy, ack, frd, fwait, frv;
    logic [18:0] addr, faddr;
    logic [3:0]  len, fburst;
    logic [31:0] data, fdata;

    logic        req0, busy0, ack0, frd0, fwait0, frv0;
    logic [18:0] addr0, faddr0;
    logic [3:0]  len0, fburst0;
    logic [31:0] data0, fdata0;

    memory_flash_burst_reader dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_request(req), .i_address(addr), .i_length(len),
        .o_busy(busy), .o_ack(ack), .o_data(data), .o_flash_read(frd),
        .o_flash_address(faddr), .o_flash_burstcount(fburst),
        .i_flash_waitrequest(fwait), .i_flash_readdatavalid(frv), .i_flash_readdata(fdata)
    );

    memory_flash_burst_reader #(.SWAP(1'b0)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_request(req0), .i_address(addr0), .i_length(len0),
        .o_busy(busy0), .o_ack(ack0), .o_data(data0), .o_flash_read(frd0),
        .o_flash_address(faddr0), .o_flash_burstcount(fburst0),
        .i_flash_waitrequest(fwait0), .i_flash_readdatavalid(frv0), .i_flash_readdata(fdata0)
    );

    int checks = 0;
    int failures = 0;

    // Raw beats and their byte-reversed forms, worked out by hand.
    logic [31:0] beat_raw [0:3] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF10};
    logic [31:0] beat_sw  [0:3] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h10FFEEDD};

    int          n_reads, ack_cnt, first_ack, last_ack, zviol, stab_viol, rst_viol;
    logic        busy_seen;
    logic [18:0] seen_addr;
    logic [3:0]  seen_burst;
    logic [31:0] ack_data [0:15];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request, then 30 observed cycles. Sampling and driving happen on the falling edge.
    task automatic run_req(input logic [18:0] a, input logic [3:0] l, input int waitc, input int rst_at);
        int pending, wc, k, rst_cnt;
        bit did_rst, have_prev;
        pending = 0; wc = 0; k = 0; rst_cnt = 0; did_rst = 0; have_prev = 0;
        n_reads = 0; ack_cnt = 0; first_ack = -1; last_ack = -1;
        zviol = 0; stab_viol = 0; rst_viol = 0; busy_seen = 0;
        seen_addr = '0; seen_burst = '0;
        for (int j = 0; j < 16; j++) ack_data[j] = 32'hFFFFFFFF;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        req = 1'b1; addr = a; len = l;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            req = 1'b0;
            frv = 1'b0;
            fwait = 1'b0;
            if (i == 1) busy_seen = busy;
            if (!rst_n && (busy || ack || data != 0 || frd || faddr != 0 || fburst != 0))
                rst_viol++;
            if (ack) begin
                if (first_ack < 0) first_ack = i;
                last_ack = i;
                if (ack_cnt < 16) ack_data[ack_cnt] = data;
                ack_cnt++;
            end else if (data != 32'd0) begin
                zviol++;
            end
            if (frd) begin
                if (have_prev && (faddr != seen_addr || fburst != seen_burst)) stab_viol++;
                have_prev = 1; seen_addr = faddr; seen_burst = fburst;
                if (wc < waitc) begin
                    wc++;
                    fwait = 1'b1;
                end else begin
                    n_reads++;
                    pending = int'(fburst);
                end
            end else if (pending > 0) begin
                frv = 1'b1;
                fdata = beat_raw[k % 4];
                k++;
                pending--;
            end
            if (rst_at > 0 && ack_cnt == rst_at && !did_rst) begin
                rst_n = 1'b0; did_rst = 1; rst_cnt = 0;
            end else if (did_rst && !rst_n) begin
                rst_cnt++;
                if (rst_cnt == 2) rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        int stray;
        req = 0; addr = '0; len = '0; fwait = 0; frv = 0; fdata = '0;
        req0 = 0; addr0 = '0; len0 = '0; fwait0 = 0; frv0 = 0; fdata0 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_fread", {31'd0, frd}, 32'd0);
        check("rst_faddr", {13'd0, faddr}, 32'd0);
        check("rst_fburst", {28'd0, fburst}, 32'd0);
        rst_n = 1'b1;

        // Full in-range burst with a two-cycle stall.
        run_req(19'h00010, 4'd4, 2, 0);
        check("t1_busy", {31'd0, busy_seen}, 32'd1);
        check("t1_reads", n_reads, 1);
        check("t1_faddr", {13'd0, seen_addr}, 32'h10);
        check("t1_burst", {28'd0, seen_burst}, 32'd4);
        check("t1_stable", stab_viol, 0);
        check("t1_acks", ack_cnt, 4);
        for (int j = 0; j < 4; j++) check($sformatf("t1_data%0d", j), ack_data[j], beat_sw[j]);
        check("t1_zero", zviol, 0);

        // Straddles FLASH_END: two flash words then two zero words.
        run_req(19'h059FE, 4'd4, 0, 0);
        check("t2_burst", {28'd0, seen_burst}, 32'd2);
        check("t2_acks", ack_cnt, 4);
        check("t2_data0", ack_data[0], 32'h44332211);
        check("t2_data1", ack_data[1], 32'h88776655);
        check("t2_data2", ack_data[2], 32'd0);
        check("t2_data3", ack_data[3], 32'd0);

        // Fully out of range: no flash access, acks at +2..+4.
        run_req(19'h06000, 4'd3, 0, 0);
        check("t3_reads", n_reads, 0);
        check("t3_acks", ack_cnt, 3);
        check("t3_first", first_ack, 2);
        check("t3_last", last_ack, 4);
        check("t3_data", ack_data[0] | ack_data[1] | ack_data[2], 32'd0);

        run_req(19'h00020, 4'd0, 1, 0);
        check("len0_burst", {28'd0, seen_burst}, 32'd1);
        check("len0_acks", ack_cnt, 1);
        run_req(19'h00020, 4'd9, 0, 0);
        check("len9_burst", {28'd0, seen_burst}, 32'd4);
        check("len9_acks", ack_cnt, 4);

        // Reset after the first ack; the remaining beats must be dropped.
        run_req(19'h00100, 4'd4, 0, 1);
        check("rst_mid_acks", ack_cnt, 1);
        check("rst_mid_data", ack_data[0], 32'h44332211);
        check("rst_mid_outs", rst_viol, 0);
        run_req(19'h00200, 4'd2, 0, 0);
        check("post_rst_burst", {28'd0, seen_burst}, 32'd2);
        check("post_rst_acks", ack_cnt, 2);
        check("post_rst_data1", ack_data[1], 32'h88776655);

        // Stray data-valid while idle.
        stray = 0;
        @(negedge clk);
        frv = 1'b1; fdata = 32'hCAFEF00D;
        repeat (3) begin
            @(negedge clk);
            if (ack || busy) stray++;
        end
        frv = 1'b0;
        @(negedge clk);
        if (ack) stray++;
        check("stray_idle", stray, 0);

        // Pass-through instance.
        req0 = 1'b1; addr0 = 19'h00004; len0 = 4'd1;
        @(negedge clk);
        req0 = 1'b0;
        check("sw0_read", {31'd0, frd0}, 32'd1);
        @(negedge clk);
        frv0 = 1'b1; fdata0 = 32'hDEADBEEF;
        @(negedge clk);
        frv0 = 1'b0;
        check("sw0_ack", {31'd0, ack0}, 32'd1);
        check("sw0_data", data0, 32'hDEADBEEF);
        @(negedge clk);
        check("sw0_idle", {31'd0, busy0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
